// File: rtl/mau_pkg.sv
// Shared MAU types: packed float format and the adder-arbiter FSM states.
package mau_pkg;

  localparam int unsigned MAU_EXP_W   = 5;
  localparam int unsigned MAU_MAN_W   = 18;
  localparam int unsigned MAU_FLOAT_W = 1 + MAU_EXP_W + MAU_MAN_W;

  typedef struct packed {
    logic                 sign;
    logic [MAU_EXP_W-1:0] exponent;
    logic [MAU_MAN_W-1:0] mantissa;
  } mau_float_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } mau_arb_state_e;

endpackage

// File: rtl/mau_rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after the pointer wins.
module mau_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant_c,
  output logic [ID_W-1:0]  o_grant_id_c,
  output logic             o_any_c
);

  always_comb begin
    o_grant_c    = '0;
    o_grant_id_c = '0;
    o_any_c      = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned w_idx;
      w_idx = (32'(i_ptr) + k) % N_REQ;
      if (!o_any_c && i_req_valid[ID_W'(w_idx)]) begin
        o_any_c                   = 1'b1;
        o_grant_c[ID_W'(w_idx)]   = 1'b1;
        o_grant_id_c              = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/mau_add_arbiter.sv
// Shares one MAU adder between N_REQ requesters: grant, start, wait fixed latency, respond.
module mau_add_arbiter
  import mau_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ADD_LATENCY = 4,
  parameter int unsigned ID_W        = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  mau_float_t [N_REQ-1:0] req_a,
  input  mau_float_t [N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output mau_float_t            rsp_c,
  output logic                  add_start,
  output logic                  add_a_sign,
  output logic [MAU_EXP_W-1:0]  add_a_exponent,
  output logic [MAU_MAN_W-1:0]  add_a_mantissa,
  output logic                  add_b_sign,
  output logic [MAU_EXP_W-1:0]  add_b_exponent,
  output logic [MAU_MAN_W-1:0]  add_b_mantissa,
  input  logic                  add_c_sign,
  input  logic [MAU_EXP_W-1:0]  add_c_exponent,
  input  logic [MAU_MAN_W-1:0]  add_c_mantissa,
  output logic                  busy
);

  localparam int unsigned     CNT_W    = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LATENCY - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  mau_arb_state_e   r_state, w_state_nxt;
  logic [ID_W-1:0]  r_ptr, r_id;
  logic [CNT_W-1:0] r_cnt;
  mau_float_t       r_a, r_b, r_c;
  logic             r_add_start, r_busy;
  logic [N_REQ-1:0] r_rsp_valid;

  logic [N_REQ-1:0] w_grant, w_rsp_oh;
  logic [ID_W-1:0]  w_grant_id;
  logic             w_any, w_accept;

  mau_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .i_req_valid (req_valid),
    .i_ptr       (r_ptr),
    .o_grant_c   (w_grant),
    .o_grant_id_c(w_grant_id),
    .o_any_c     (w_any)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ARB_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state; req_ready is offered only while idle.
  always_comb begin
    w_state_nxt        = r_state;
    w_accept           = 1'b0;
    req_ready          = '0;
    w_rsp_oh           = '0;
    w_rsp_oh[r_id]     = 1'b1;
    case (r_state)
      ARB_IDLE: begin
        req_ready = w_grant;
        if (w_any) begin
          w_accept    = 1'b1;
          w_state_nxt = ARB_START;
        end
      end
      ARB_START: w_state_nxt = ARB_WAIT;
      ARB_WAIT:  if (r_cnt == '0) w_state_nxt = ARB_RESP;
      ARB_RESP:  if (rsp_ready[r_id]) w_state_nxt = ARB_IDLE;
      default:   w_state_nxt = ARB_IDLE;
    endcase
  end

  // Datapath plus outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_add_start <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      if (w_accept) begin
        r_id  <= w_grant_id;
        r_a   <= req_a[w_grant_id];
        r_b   <= req_b[w_grant_id];
        r_ptr <= (w_grant_id == ID_LAST) ? '0 : w_grant_id + ID_W'(1);
      end
      if (r_state == ARB_START)                       r_cnt <= CNT_LOAD;
      else if (r_state == ARB_WAIT && r_cnt != '0)    r_cnt <= r_cnt - CNT_W'(1);
      if (r_state == ARB_WAIT && r_cnt == '0)
        r_c <= '{sign: add_c_sign, exponent: add_c_exponent, mantissa: add_c_mantissa};
      r_add_start <= (w_state_nxt == ARB_START);
      r_busy      <= (w_state_nxt != ARB_IDLE);
      r_rsp_valid <= (w_state_nxt == ARB_RESP) ? w_rsp_oh : '0;
    end
  end

  assign add_start      = r_add_start;
  assign busy           = r_busy;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_c          = r_c;
  assign add_a_sign     = r_a.sign;
  assign add_a_exponent = r_a.exponent;
  assign add_a_mantissa = r_a.mantissa;
  assign add_b_sign     = r_b.sign;
  assign add_b_exponent = r_b.exponent;
  assign add_b_mantissa = r_b.mantissa;

endmodule

// File: tb/tb_mau_add_arbiter.sv
// Directed bench for mau_add_arbiter: default instance plus an N_REQ=2, ADD_LATENCY=1 instance.
module tb_mau_add_arbiter;
  import mau_pkg::*;

  localparam int unsigned L0 = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder stub: output changes every cycle so the capture cycle is observable.
  function automatic mau_float_t stub(input int c);
    logic [31:0] v;
    v = 32'(c);
    stub = {v[0], v[4:0], 18'(c * 37 + 11)};
  endfunction

  mau_float_t w_stub;
  assign w_stub = stub(cyc);

  logic [3:0]       rv0, rr0, req_ready0, rsp_valid0;
  mau_float_t [3:0] ra0, rb0;
  mau_float_t       rsp_c0;
  logic             add_start0, busy0, a0s, b0s;
  logic [4:0]       a0e, b0e;
  logic [17:0]      a0m, b0m;
  logic [23:0]      w_a0, w_b0;
  assign w_a0 = {a0s, a0e, a0m};
  assign w_b0 = {b0s, b0e, b0m};

  logic [1:0]       rv1, rr1, req_ready1, rsp_valid1;
  mau_float_t [1:0] ra1, rb1;
  mau_float_t       rsp_c1;
  logic             add_start1, busy1, a1s, b1s;
  logic [4:0]       a1e, b1e;
  logic [17:0]      a1m, b1m;

  mau_add_arbiter #(.N_REQ(4), .ADD_LATENCY(L0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(rv0), .req_ready(req_ready0),
    .req_a(ra0), .req_b(rb0), .rsp_valid(rsp_valid0), .rsp_ready(rr0), .rsp_c(rsp_c0),
    .add_start(add_start0),
    .add_a_sign(a0s), .add_a_exponent(a0e), .add_a_mantissa(a0m),
    .add_b_sign(b0s), .add_b_exponent(b0e), .add_b_mantissa(b0m),
    .add_c_sign(w_stub.sign), .add_c_exponent(w_stub.exponent), .add_c_mantissa(w_stub.mantissa),
    .busy(busy0)
  );

  mau_add_arbiter #(.N_REQ(2), .ADD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(req_ready1),
    .req_a(ra1), .req_b(rb1), .rsp_valid(rsp_valid1), .rsp_ready(rr1), .rsp_c(rsp_c1),
    .add_start(add_start1),
    .add_a_sign(a1s), .add_a_exponent(a1e), .add_a_mantissa(a1m),
    .add_b_sign(b1s), .add_b_exponent(b1e), .add_b_mantissa(b1m),
    .add_c_sign(w_stub.sign), .add_c_exponent(w_stub.exponent), .add_c_mantissa(w_stub.mantissa),
    .busy(busy1)
  );

  int errors = 0;
  int checks = 0;
  int last_acc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on dut0 from the IDLE offer through the response handshake.
  task automatic do_op(input int g, input int gap, input int stall,
                       input logic [3:0] v_start, input logic [3:0] v_wait);
    int acc;
    logic [3:0] oh;
    mau_float_t exp_c;
    oh = 4'b0001 << g;
    #1;
    check("grant", 32'(req_ready0), 32'(oh));
    check("idle_busy", 32'(busy0), 0);
    if (gap > 0) check("gap", 32'(cyc - last_acc), 32'(gap));
    acc = cyc;
    last_acc = cyc;
    tick();
    rv0 = v_start;
    #1;
    check("start", 32'(add_start0), 1);
    check("start_op_a", 32'(w_a0), 32'(ra0[2'(g)]));
    check("start_op_b", 32'(w_b0), 32'(rb0[2'(g)]));
    check("start_rdy", 32'(req_ready0), 0);
    check("start_busy", 32'(busy0), 1);
    for (int i = 0; i < int'(L0); i++) begin
      tick();
      if (i == 1) rv0 = v_wait;
      #1;
      check("wait_start", 32'(add_start0), 0);
      check("wait_rsp", 32'(rsp_valid0), 0);
      check("wait_rdy", 32'(req_ready0), 0);
      check("wait_op_a", 32'(w_a0), 32'(ra0[2'(g)]));
      check("wait_op_b", 32'(w_b0), 32'(rb0[2'(g)]));
    end
    exp_c = stub(acc + 1 + int'(L0));
    for (int k = 0; k <= stall; k++) begin
      tick();
      rr0[2'(g)] = (k == stall);
      #1;
      check("rsp_valid", 32'(rsp_valid0), 32'(oh));
      check("rsp_c", 32'(rsp_c0), 32'(exp_c));
      check("rsp_rdy", 32'(req_ready0), 0);
      check("rsp_busy", 32'(busy0), 1);
    end
    tick();
    rr0 = '1;
    #1;
    check("done_busy", 32'(busy0), 0);
    check("done_rsp", 32'(rsp_valid0), 0);
  endtask

  initial begin
    int acc1, nacc, nrsp, exp_id, lid;
    reset = 1'b1;
    rv0 = '0; rr0 = '1; rv1 = '0; rr1 = '1;
    for (int i = 0; i < 4; i++) begin
      ra0[i] = 24'(32'h012345 + i * 32'h011111);
      rb0[i] = 24'(32'h876543 + i * 32'h010101);
    end
    ra0[2] = 24'b0_01110_110111011100000000;
    rb0[2] = 24'b1_01110_110111011010000000;
    ra1[0] = 24'h0A0B0C; rb1[0] = 24'h8C0D0E;
    ra1[1] = 24'h112233; rb1[1] = 24'h445566;

    // Reset values
    tick(); tick(); #1;
    check("rst_rdy", 32'(req_ready0), 0);
    check("rst_rsp", 32'(rsp_valid0), 0);
    check("rst_c", 32'(rsp_c0), 0);
    check("rst_start", 32'(add_start0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_op_a", 32'(w_a0), 0);
    check("rst_op_b", 32'(w_b0), 0);

    // Single request from requester 2
    reset = 1'b0;
    rv0 = 4'b0100;
    do_op(2, 0, 0, 4'b0000, 4'b0000);

    // Fairness from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rv0 = '1;
    do_op(0, 0, 0, '1, '1);
    do_op(1, 7, 0, '1, '1);
    do_op(2, 7, 0, '1, '1);
    do_op(3, 7, 0, '1, '1);
    do_op(0, 7, 0, '1, '1);
    do_op(1, 7, 0, '1, '1);

    // Response stall on requester 1 while everyone else waits
    rv0 = 4'b0010;
    do_op(1, 0, 10, '1, '1);
    do_op(2, 17, 0, 4'b0000, 4'b0000);

    // Reset in the first WAIT cycle
    rv0 = 4'b1001;
    #1;
    check("rw_grant", 32'(req_ready0), 32'(4'b1000));
    tick(); #1;
    check("rw_start", 32'(add_start0), 1);
    tick();
    reset = 1'b1;
    rv0 = '0;
    tick(); #1;
    check("rw_rsp", 32'(rsp_valid0), 0);
    check("rw_c", 32'(rsp_c0), 0);
    check("rw_start0", 32'(add_start0), 0);
    check("rw_busy", 32'(busy0), 0);
    check("rw_op_a", 32'(w_a0), 0);
    check("rw_op_b", 32'(w_b0), 0);
    check("rw_rdy", 32'(req_ready0), 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      check("rw_no_rsp", 32'(rsp_valid0), 0);
      check("rw_idle", 32'(busy0), 0);
    end
    rv0 = 4'b1001;
    do_op(0, 0, 0, 4'b0000, 4'b0000);

    // Requester 3 raises then withdraws while 1 stays valid
    rv0 = 4'b0100;
    do_op(2, 0, 0, 4'b1010, 4'b0010);
    do_op(1, 7, 0, 4'b0000, 4'b0000);

    // Small instance: alternating grants, accept-to-response latency of 3
    rv0 = '0;
    rv1 = 2'b11;
    acc1 = 0; nacc = 0; nrsp = 0; exp_id = 0; lid = 0;
    for (int i = 0; i < 32; i++) begin
      #1;
      if (req_ready1 != 2'b00) begin
        check("sw_grant", 32'(req_ready1), 32'(2'b01 << exp_id));
        if (nacc > 0) check("sw_gap", 32'(cyc - acc1), 4);
        acc1 = cyc;
        lid = exp_id;
        exp_id = 1 - exp_id;
        nacc++;
      end
      if (rsp_valid1 != 2'b00) begin
        check("sw_lat", 32'(cyc - acc1), 3);
        check("sw_id", 32'(rsp_valid1), 32'(2'b01 << lid));
        check("sw_c", 32'(rsp_c1), 32'(stub(acc1 + 2)));
        nrsp++;
      end
      tick();
    end
    check("sw_accepts", 32'(nacc), 8);
    check("sw_rsps", 32'(nrsp), 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mau_add_arbiter.md
# mau_add_arbiter

Round-robin arbiter and sequencer that shares one MAU_Adder between `N_REQ` matrix-lane requesters in the Matrix Acceleration Unit. Each requester posts a pair of MAU floating-point operands through a valid/ready handshake. The arbiter grants one requester, holds the operands stable, pulses the adder's `start`, and waits a fixed latency. It then captures the sum and returns it to the granted requester through a valid/ready response handshake.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8)
- `ADD_LATENCY`, 4: cycles from the `add_start` pulse to a valid adder result (≥1)
- `ID_W`, `$clog2(N_REQ)`: grant index width

Ports:
- `clk`  in  1  the single clock; all logic is on the rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  N_REQ  per-requester operand pair valid
- `req_ready`  out  N_REQ  per-requester accept; at most one bit high
- `req_a`, `req_b`  in  N_REQ × 24  operands, packed {sign, exponent[4:0], mantissa[17:0]}
- `rsp_valid`  out  N_REQ  per-requester result valid; at most one bit high
- `rsp_ready`  in  N_REQ  per-requester result accept
- `rsp_c`  out  24  result, shared by all requesters and meaningful only where `rsp_valid` is set
- `add_start`  out  1  one-cycle start pulse to the adder
- `add_a_sign`/`add_a_exponent`/`add_a_mantissa`, `add_b_*`  out  1/5/18  adder operands
- `add_c_sign`/`add_c_exponent`/`add_c_mantissa`  in  1/5/18  adder result
- `busy`  out  1  high in any state other than IDLE

## Operation
- The FSM has four states: IDLE → START → WAIT → RESP → IDLE.
- IDLE:
  - Compute the round-robin grant `g` among the set `req_valid` bits and drive `req_ready[g]=1`.
  - On the handshake, latch `req_a[g]`, `req_b[g]` and `g`, advance the priority pointer to `g+1` mod N_REQ, and go to START.
  - With no valid request, stay in IDLE.
- START:
  - `add_start=1` for exactly this cycle.
  - Load the counter with `ADD_LATENCY-1` and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where the counter is 0, capture `add_c_*` into the result register and go to RESP.
- RESP:
  - Assert `rsp_valid[id]` with `rsp_c` = the captured result.
  - When `rsp_ready[id]` is high, go to IDLE.
  - Otherwise hold, with `rsp_c` stable.
- The `add_a_*`/`add_b_*` outputs come from the latched operand registers and stay constant from START until the result is captured.
- Round-robin priority:
  - After reset, index 0 has the highest priority.
  - Search order is pointer, pointer+1, …, wrapping at N_REQ.
- Operands are passed through with no modification or arithmetic.
- A requester that drops `req_valid` before its handshake loses nothing. A request is committed only on `req_valid & req_ready`.
- `rsp_ready` bits for requesters other than `id` are ignored.
- Reset at any time:
  - The FSM returns to IDLE and the in-flight operation is discarded with no response.
  - The pointer returns to 0.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_c=0`, `add_start=0`, `add_*` operands 0, `busy=0`, FSM IDLE, pointer 0.
- `req_ready` is combinational from `req_valid` and the pointer, and only in IDLE. There is no other combinational input-to-output path.
- Accept at the edge ending cycle t produces:
  - `add_start` high in cycle t+1
  - result captured at the end of cycle t+1+ADD_LATENCY
  - `rsp_valid` high from cycle t+2+ADD_LATENCY
- Back-to-back throughput: the minimum interval between accepts is ADD_LATENCY+3 cycles, with zero response stall.
- When `rsp_ready` is held high, the response lasts exactly one cycle. The next grant can be offered in the cycle after the response handshake.

## Structure
- Shared package `mau_pkg` holds:
  - `mau_float_t` packed struct {sign; exponent[4:0]; mantissa[17:0]}
  - width constants `MAU_EXP_W=5`, `MAU_MAN_W=18`
  - the FSM state enum `mau_arb_state_e`
- One sub-module is natural: `mau_rr_arbiter`, a purely combinational round-robin grant from (`req_valid`, pointer) to a one-hot grant plus index.
- The counter, operand registers and result register stay in the top module.

## Test plan
- Single request:
  - Stimulus: requester 2 posts a = {0, 5'b01110, 18'b110111011100000000}, b = {1, 5'b01110, 18'b110111011010000000} at t=0, with `rsp_ready[2]` held high.
  - Required: `add_start` only in cycle 1; operands stable through cycle 5; `rsp_valid[2]` in cycle 6 only; `rsp_c` equals the adder stub's output sampled at cycle 5.
- Fairness: all four requesters are continuously valid. Grants must go in order 0,1,2,3,0,1, each ADD_LATENCY+3 = 7 cycles apart.
- Response stall:
  - Stimulus: `rsp_ready[1]` is held low for 10 cycles.
  - Required: `rsp_valid[1]` and `rsp_c` stay constant; no `req_ready` is asserted; `busy=1`.
  - After `rsp_ready` rises, the next grant follows one cycle later.
- Reset in WAIT:
  - Stimulus: assert `reset` in the cycle after `add_start`.
  - Required: all outputs are 0 in the next cycle, no `rsp_valid` ever appears for that op, and the next grant goes to requester 0 even if requester 3 is also valid.
- Withdrawn request:
  - Stimulus: requester 3 raises and drops `req_valid` while the FSM is in WAIT, and requester 1 stays valid.
  - Required: after the current response completes, requester 1 is granted, and requester 3 receives no response.
- Parameter sweep: run with N_REQ=2 and ADD_LATENCY=1. Latency from accept to `rsp_valid` must be 3 cycles, and grants must alternate 0,1.
